// File: rtl/ddr2_init_sequencer_if.sv
// User-side bus of the DDR2 init sequencer: pass-through command/address/bank,
// the initialised flag and the refresh request/grant handshake.
interface ddr2_init_sequencer_if #(
   parameter int ADDR_W = 14,
   parameter int BANK_W = 3
);
   logic              REINIT_REQ;
   logic [2:0]        COMMAND_USER;
   logic [ADDR_W-1:0] ADDRESS_USER;
   logic [BANK_W-1:0] BANK_USER;
   logic              RST_USER;
   logic              REFRESH_REQ;
   logic              REFRESH_GNT;

   modport master (
      output REINIT_REQ, COMMAND_USER, ADDRESS_USER, BANK_USER, REFRESH_GNT,
      input  RST_USER, REFRESH_REQ
   );

   modport slave (
      input  REINIT_REQ, COMMAND_USER, ADDRESS_USER, BANK_USER, REFRESH_GNT,
      output RST_USER, REFRESH_REQ
   );
endinterface

// File: rtl/ddr2_init_sequencer.sv
// DDR2 power-up / mode-register sequencer with re-init and periodic refresh
// insertion; owns the SDRAM pins until initialised, then muxes the user bus through.
module ddr2_init_sequencer #(
   parameter int                ADDR_W           = 14,
   parameter int                BANK_W           = 3,
   parameter int                POWERUP_CYCLES   = 200,
   parameter int                GAP_CYCLES       = 32,
   parameter int                SETTLE_CYCLES    = 256,
   parameter int                REFRESH_INTERVAL = 0,
   parameter logic [ADDR_W-1:0] MR_DLLRST        = 'h532,
   parameter logic [ADDR_W-1:0] MR_NORMAL        = 'h432,
   parameter logic [ADDR_W-1:0] EMR_OCD          = 'h780,
   parameter logic [ADDR_W-1:0] EMR_FINAL        = 'h400,
   parameter logic [ADDR_W-1:0] EMR2             = 'h000,
   parameter logic [ADDR_W-1:0] EMR3             = 'h000
) (
   input  logic                 CLK_n,
   input  logic                 RST,
   ddr2_init_sequencer_if.slave usr,
   output logic                 CKE,
   output logic [2:0]           COMMAND_PIN,
   output logic [ADDR_W-1:0]    ADDRESS_PIN,
   output logic [BANK_W-1:0]    BANK_PIN,
   output logic [3:0]           STAGE
);

   localparam logic [2:0] CMD_NOOP = 3'b111;
   localparam logic [2:0] CMD_PRCH = 3'b010;
   localparam logic [2:0] CMD_ARSR = 3'b001;
   localparam logic [2:0] CMD_MRST = 3'b000;

   localparam logic [ADDR_W-1:0] ALL_BANKS = ADDR_W'('h400);

   localparam int MAX_PG  = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
   localparam int MAX_CNT = (MAX_PG > SETTLE_CYCLES) ? MAX_PG : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam int TMR_W   = (REFRESH_INTERVAL < 1) ? 1 : $clog2(REFRESH_INTERVAL + 1);
   localparam int ROM_W   = 3 + ADDR_W + BANK_W;

   typedef enum logic [3:0] {
      S_POWERUP,
      S_CKE_WAIT,
      S_ISSUE,
      S_GAP,
      S_SETTLE,
      S_RUN,
      S_REF_REQ,
      S_REF_PRCH,
      S_REF_GAP1,
      S_REF_ARSR,
      S_REF_GAP2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [3:0]        stage_q, stage_d;
   logic [2:0]        cmd_q, cmd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BANK_W-1:0] bank_q, bank_d;
   logic              cke_q, cke_d;
   logic              rst_user_q, rst_user_d;
   logic              req_q, req_d;
   logic              user_sel_q, user_sel_d;

   // JEDEC init steps, indexed by STAGE; entries 6 and 7 are the two auto-refreshes
   function automatic logic [ROM_W-1:0] rom_entry(input logic [3:0] idx);
      logic [2:0]        c;
      logic [ADDR_W-1:0] a;
      logic [BANK_W-1:0] b;
      c = CMD_MRST;
      a = '0;
      b = '0;
      case (idx)
         4'd0:       begin c = CMD_PRCH; a = ALL_BANKS; b = BANK_W'(1); end
         4'd1:       begin a = EMR2;      b = BANK_W'(2); end
         4'd2:       begin a = EMR3;      b = BANK_W'(3); end
         4'd3:       begin a = EMR_OCD;   b = BANK_W'(1); end
         4'd4:       begin a = MR_DLLRST; end
         4'd5:       begin c = CMD_PRCH; a = ALL_BANKS; end
         4'd6, 4'd7: begin c = CMD_ARSR; a = ALL_BANKS; end
         4'd8:       begin a = MR_NORMAL; end
         4'd9:       begin a = EMR_OCD;   b = BANK_W'(1); end
         default:    begin a = EMR_FINAL; b = BANK_W'(1); end
      endcase
      return {c, a, b};
   endfunction

   always_ff @(posedge CLK_n or posedge RST) begin
      if (RST) begin
         state_q    <= S_POWERUP;
         cnt_q      <= '0;
         timer_q    <= '0;
         stage_q    <= '0;
         cmd_q      <= CMD_NOOP;
         addr_q     <= '0;
         bank_q     <= '0;
         cke_q      <= 1'b0;
         rst_user_q <= 1'b0;
         req_q      <= 1'b0;
         user_sel_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         timer_q    <= timer_d;
         stage_q    <= stage_d;
         cmd_q      <= cmd_d;
         addr_q     <= addr_d;
         bank_q     <= bank_d;
         cke_q      <= cke_d;
         rst_user_q <= rst_user_d;
         req_q      <= req_d;
         user_sel_q <= user_sel_d;
      end
   end

   // Commands are loaded on the edge that enters ISSUE/REF_PRCH/REF_ARSR, so the
   // pins show them during that state; every other cycle the internal command is NOOP.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      timer_d    = timer_q;
      stage_d    = stage_q;
      cmd_d      = CMD_NOOP;
      addr_d     = addr_q;
      bank_d     = bank_q;
      cke_d      = cke_q;
      rst_user_d = rst_user_q;
      req_d      = req_q;
      user_sel_d = user_sel_q;

      if (usr.REINIT_REQ) begin
         state_d    = S_POWERUP;
         cnt_d      = '0;
         timer_d    = '0;
         stage_d    = '0;
         addr_d     = '0;
         bank_d     = '0;
         cke_d      = 1'b0;
         rst_user_d = 1'b0;
         req_d      = 1'b0;
         user_sel_d = 1'b0;
      end else begin
         unique case (state_q)
            S_POWERUP: begin
               if (cnt_q == CNT_W'(POWERUP_CYCLES - 1)) begin
                  state_d = S_CKE_WAIT;
                  cnt_d   = '0;
                  cke_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_CKE_WAIT: begin
               if (cnt_q == CNT_W'(GAP_CYCLES)) begin
                  state_d                  = S_ISSUE;
                  cnt_d                    = '0;
                  {cmd_d, addr_d, bank_d}  = rom_entry(stage_q);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_ISSUE: begin
               state_d = S_GAP;
               cnt_d   = '0;
            end
            S_GAP: begin
               if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                  cnt_d = '0;
                  if (stage_q == 4'd10) begin
                     state_d = S_SETTLE;
                  end else begin
                     state_d                 = S_ISSUE;
                     stage_d                 = stage_q + 4'd1;
                     {cmd_d, addr_d, bank_d} = rom_entry(stage_q + 4'd1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_SETTLE: begin
               if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                  state_d    = S_RUN;
                  cnt_d      = '0;
                  rst_user_d = 1'b1;
                  user_sel_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_RUN: begin
               if (REFRESH_INTERVAL != 0) begin
                  if (timer_q == TMR_W'(REFRESH_INTERVAL - 1)) begin
                     state_d = S_REF_REQ;
                     req_d   = 1'b1;
                     timer_d = TMR_W'(REFRESH_INTERVAL);
                  end else begin
                     timer_d = timer_q + TMR_W'(1);
                  end
               end
            end
            S_REF_REQ: begin
               if (usr.REFRESH_GNT) begin
                  state_d    = S_REF_PRCH;
                  req_d      = 1'b0;
                  user_sel_d = 1'b0;
                  cmd_d      = CMD_PRCH;
                  addr_d     = ALL_BANKS;
                  bank_d     = '0;
               end
            end
            S_REF_PRCH: begin
               state_d = S_REF_GAP1;
               cnt_d   = '0;
            end
            S_REF_GAP1: begin
               if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                  state_d = S_REF_ARSR;
                  cnt_d   = '0;
                  cmd_d   = CMD_ARSR;
                  addr_d  = ALL_BANKS;
                  bank_d  = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_REF_ARSR: begin
               state_d = S_REF_GAP2;
               cnt_d   = '0;
            end
            S_REF_GAP2: begin
               if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                  state_d    = S_RUN;
                  cnt_d      = '0;
                  timer_d    = '0;
                  user_sel_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = S_POWERUP;
            end
         endcase
      end
   end

   assign COMMAND_PIN     = user_sel_q ? usr.COMMAND_USER : cmd_q;
   assign ADDRESS_PIN     = user_sel_q ? usr.ADDRESS_USER : addr_q;
   assign BANK_PIN        = user_sel_q ? usr.BANK_USER    : bank_q;
   assign CKE             = cke_q;
   assign STAGE           = stage_q;
   assign usr.RST_USER    = rst_user_q;
   assign usr.REFRESH_REQ = req_q;

endmodule

// File: tb/tb_ddr2_init_sequencer.sv
// Randomized bench for ddr2_init_sequencer: an edge-count based reference model
// checked every cycle, plus hand-computed pin values for P=4, G=2, S=3, INTERVAL=10.
module tb_ddr2_init_sequencer;

   localparam int ADDR_W    = 14;
   localparam int BANK_W    = 3;
   localparam int P         = 4;
   localparam int G         = 2;
   localparam int S         = 3;
   localparam int INTERVAL  = 10;
   localparam int FIRST_CMD = P + G + 1;
   localparam int T_RUN     = FIRST_CMD + 11 * (G + 1) + S;

   localparam logic [2:0] NOOP = 3'b111;
   localparam logic [2:0] PRCH = 3'b010;
   localparam logic [2:0] ARSR = 3'b001;
   localparam logic [2:0] MRST = 3'b000;

   logic              CLK_n = 1'b0;
   logic              RST   = 1'b1;
   logic              CKE;
   logic [2:0]        COMMAND_PIN;
   logic [ADDR_W-1:0] ADDRESS_PIN;
   logic [BANK_W-1:0] BANK_PIN;
   logic [3:0]        STAGE;

   int tests_run    = 0;
   int tests_failed = 0;
   int edge_no      = 0;

   logic [2:0] rom_c [0:10] = '{PRCH, MRST, MRST, MRST, MRST, PRCH, ARSR, ARSR, MRST, MRST, MRST};
   int         rom_a [0:10] = '{'h400, 'h000, 'h000, 'h780, 'h532, 'h400, 'h400, 'h400, 'h432, 'h780, 'h400};
   int         rom_b [0:10] = '{1, 2, 3, 1, 0, 0, 0, 0, 0, 1, 1};

   // Model: edges since init start, RUN edges since last refresh, edges since grant
   int m_e   = 0;
   int m_run = 0;
   int m_ref = -1;
   bit m_req = 1'b0;

   ddr2_init_sequencer_if #(.ADDR_W(ADDR_W), .BANK_W(BANK_W)) usr ();

   ddr2_init_sequencer #(
      .ADDR_W(ADDR_W), .BANK_W(BANK_W), .POWERUP_CYCLES(P), .GAP_CYCLES(G),
      .SETTLE_CYCLES(S), .REFRESH_INTERVAL(INTERVAL)
   ) dut (
      .CLK_n(CLK_n), .RST(RST), .usr(usr), .CKE(CKE), .COMMAND_PIN(COMMAND_PIN),
      .ADDRESS_PIN(ADDRESS_PIN), .BANK_PIN(BANK_PIN), .STAGE(STAGE)
   );

   always #5 CLK_n = ~CLK_n;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   always @(posedge CLK_n or posedge RST) begin
      if (RST || usr.REINIT_REQ) begin
         m_e = 0; m_run = 0; m_ref = -1; m_req = 1'b0;
      end else if (m_e < T_RUN) begin
         m_e = m_e + 1;
      end else if (m_ref >= 0) begin
         m_ref = m_ref + 1;
         if (m_ref == 2 * G + 2) begin
            m_ref = -1;
            m_run = 0;
         end
      end else if (m_req) begin
         if (usr.REFRESH_GNT) begin
            m_req = 1'b0;
            m_ref = 0;
         end
      end else if (INTERVAL != 0) begin
         m_run = m_run + 1;
         if (m_run == INTERVAL) m_req = 1'b1;
      end
   end

   task automatic compareModel();
      bit         in_run, sel, chk_ab;
      int         k, exp_addr, exp_bank, exp_stage;
      logic [2:0] exp_cmd;
      in_run   = (m_e >= T_RUN);
      sel      = in_run && (m_ref < 0);
      chk_ab   = 1'b1;
      exp_cmd  = NOOP;
      exp_addr = 0;
      exp_bank = 0;
      if (sel) begin
         exp_cmd  = usr.COMMAND_USER;
         exp_addr = int'(usr.ADDRESS_USER);
         exp_bank = int'(usr.BANK_USER);
      end else if (in_run) begin
         if (m_ref == 0) begin
            exp_cmd  = PRCH;
            exp_addr = 'h400;
         end else begin
            chk_ab = 1'b0;
            if (m_ref == G + 1) exp_cmd = ARSR;
         end
      end else begin
         k = -1;
         if (m_e >= FIRST_CMD && (m_e - FIRST_CMD) % (G + 1) == 0) k = (m_e - FIRST_CMD) / (G + 1);
         if (k >= 0 && k <= 10) begin
            exp_cmd  = rom_c[k];
            exp_addr = rom_a[k];
            exp_bank = rom_b[k];
         end else begin
            chk_ab = 1'b0;
         end
      end
      if (in_run)              exp_stage = 10;
      else if (m_e < FIRST_CMD) exp_stage = 0;
      else                     exp_stage = ((m_e - FIRST_CMD) / (G + 1) > 10) ? 10 : (m_e - FIRST_CMD) / (G + 1);

      checkOutput("model_cke", 32'(CKE), 32'(m_e >= P));
      checkOutput("model_rst_user", 32'(usr.RST_USER), 32'(in_run));
      checkOutput("model_refresh_req", 32'(usr.REFRESH_REQ), 32'(m_req));
      checkOutput("model_stage", 32'(STAGE), exp_stage);
      checkOutput("model_command", 32'(COMMAND_PIN), 32'(exp_cmd));
      if (chk_ab) begin
         checkOutput("model_address", 32'(ADDRESS_PIN), exp_addr);
         checkOutput("model_bank", 32'(BANK_PIN), exp_bank);
      end
   endtask

   always @(negedge CLK_n) compareModel();

   task automatic applyStimulus(input bit reinit, input bit gnt);
      usr.REINIT_REQ   = reinit;
      usr.REFRESH_GNT  = gnt;
      usr.COMMAND_USER = 3'($urandom);
      usr.ADDRESS_USER = ADDR_W'($urandom);
      usr.BANK_USER    = BANK_W'($urandom);
      @(posedge CLK_n);
      #1;
      edge_no++;
   endtask

   // Edge numbers below are hand-computed for P=4, G=2, S=3
   task automatic runInit(input int last_edge);
      while (edge_no < last_edge) begin
         applyStimulus(1'b0, 1'b0);
         case (edge_no)
            3:  checkOutput("cke_low_edge3", 32'(CKE), 0);
            4:  checkOutput("cke_high_edge4", 32'(CKE), 1);
            6:  checkOutput("noop_edge6", 32'(COMMAND_PIN), 32'(NOOP));
            7: begin
               checkOutput("cmd0_command", 32'(COMMAND_PIN), 32'(3'b010));
               checkOutput("cmd0_address", 32'(ADDRESS_PIN), 'h400);
               checkOutput("cmd0_bank", 32'(BANK_PIN), 1);
            end
            8:  checkOutput("noop_edge8", 32'(COMMAND_PIN), 32'(NOOP));
            10: begin
               checkOutput("cmd1_command", 32'(COMMAND_PIN), 32'(3'b000));
               checkOutput("cmd1_bank", 32'(BANK_PIN), 2);
               checkOutput("cmd1_stage", 32'(STAGE), 1);
            end
            16: begin
               checkOutput("cmd3_address", 32'(ADDRESS_PIN), 'h780);
               checkOutput("cmd3_bank", 32'(BANK_PIN), 1);
            end
            37: begin
               checkOutput("cmd10_command", 32'(COMMAND_PIN), 32'(3'b000));
               checkOutput("cmd10_address", 32'(ADDRESS_PIN), 'h400);
               checkOutput("cmd10_stage", 32'(STAGE), 10);
            end
            42: checkOutput("rst_user_low_edge42", 32'(usr.RST_USER), 0);
            43: begin
               checkOutput("rst_user_high_edge43", 32'(usr.RST_USER), 1);
               checkOutput("passthru_command", 32'(COMMAND_PIN), 32'(usr.COMMAND_USER));
               checkOutput("passthru_address", 32'(ADDRESS_PIN), 32'(usr.ADDRESS_USER));
               checkOutput("passthru_bank", 32'(BANK_PIN), 32'(usr.BANK_USER));
            end
            default: ;
         endcase
      end
   endtask

   task automatic waitForReq();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 4 * INTERVAL + 4 * G + 10 && !ok; i++) begin
         applyStimulus(1'b0, 1'b0);
         if (usr.REFRESH_REQ) ok = 1'b1;
      end
      checkOutput("wait_refresh_req", 32'(ok), 1);
   endtask

   initial begin
      usr.REINIT_REQ   = 1'b0;
      usr.REFRESH_GNT  = 1'b0;
      usr.COMMAND_USER = 3'b011;
      usr.ADDRESS_USER = ADDR_W'('h1234);
      usr.BANK_USER    = BANK_W'(5);
      repeat (3) @(posedge CLK_n);
      #1;
      checkOutput("reset_cke", 32'(CKE), 0);
      checkOutput("reset_command", 32'(COMMAND_PIN), 32'(NOOP));
      checkOutput("reset_address", 32'(ADDRESS_PIN), 0);
      checkOutput("reset_rst_user", 32'(usr.RST_USER), 0);
      checkOutput("reset_refresh_req", 32'(usr.REFRESH_REQ), 0);
      checkOutput("reset_stage", 32'(STAGE), 0);
      RST     = 1'b0;
      edge_no = 0;
      runInit(T_RUN);

      // Refresh handshake with hand-counted spacing
      for (int i = 1; i <= INTERVAL; i++) begin
         applyStimulus(1'b0, 1'b0);
         if (i == INTERVAL - 1) checkOutput("req_low_before_interval", 32'(usr.REFRESH_REQ), 0);
      end
      checkOutput("req_high_after_interval", 32'(usr.REFRESH_REQ), 1);
      repeat (5) begin
         applyStimulus(1'b0, 1'b0);
         checkOutput("req_held_no_gnt", 32'(usr.REFRESH_REQ), 1);
         checkOutput("user_cmd_while_req", 32'(COMMAND_PIN), 32'(usr.COMMAND_USER));
         checkOutput("user_addr_while_req", 32'(ADDRESS_PIN), 32'(usr.ADDRESS_USER));
      end
      applyStimulus(1'b0, 1'b1);
      checkOutput("ref_prch_command", 32'(COMMAND_PIN), 32'(3'b010));
      checkOutput("ref_prch_address", 32'(ADDRESS_PIN), 'h400);
      checkOutput("ref_prch_bank", 32'(BANK_PIN), 0);
      checkOutput("ref_req_dropped", 32'(usr.REFRESH_REQ), 0);
      checkOutput("ref_rst_user_kept", 32'(usr.RST_USER), 1);
      for (int i = 1; i <= G + 1; i++) begin
         applyStimulus(1'b0, 1'b0);
         if (i == G) checkOutput("ref_gap1_noop", 32'(COMMAND_PIN), 32'(NOOP));
      end
      checkOutput("ref_arsr_command", 32'(COMMAND_PIN), 32'(3'b001));
      for (int i = 1; i <= G + 1; i++) begin
         applyStimulus(1'b0, 1'b0);
         if (i == G) checkOutput("ref_gap2_noop", 32'(COMMAND_PIN), 32'(NOOP));
      end
      checkOutput("ref_user_back_cmd", 32'(COMMAND_PIN), 32'(usr.COMMAND_USER));
      checkOutput("ref_user_back_addr", 32'(ADDRESS_PIN), 32'(usr.ADDRESS_USER));
      for (int i = 1; i <= INTERVAL; i++) begin
         applyStimulus(1'b0, 1'b0);
         if (i == INTERVAL - 1) checkOutput("req2_low_before_interval", 32'(usr.REFRESH_REQ), 0);
      end
      checkOutput("req2_high_after_interval", 32'(usr.REFRESH_REQ), 1);

      repeat (300) applyStimulus(1'b0, ($urandom_range(0, 2) == 0));

      // Reinit during REF_GAP1
      waitForReq();
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("reinit_cke", 32'(CKE), 0);
      checkOutput("reinit_rst_user", 32'(usr.RST_USER), 0);
      checkOutput("reinit_refresh_req", 32'(usr.REFRESH_REQ), 0);
      checkOutput("reinit_command", 32'(COMMAND_PIN), 32'(NOOP));
      edge_no = 0;
      runInit(T_RUN);

      // Reinit and grant on the same edge
      waitForReq();
      applyStimulus(1'b1, 1'b1);
      checkOutput("collide_no_prch", 32'(COMMAND_PIN), 32'(NOOP));
      checkOutput("collide_cke", 32'(CKE), 0);
      checkOutput("collide_rst_user", 32'(usr.RST_USER), 0);
      repeat (6) applyStimulus(1'b1, 1'b0);
      checkOutput("reinit_held_cke", 32'(CKE), 0);
      checkOutput("reinit_held_stage", 32'(STAGE), 0);
      edge_no = 0;
      runInit(16);

      // Async reset during an ISSUE cycle
      #1 RST = 1'b1;
      #1;
      checkOutput("async_rst_cke", 32'(CKE), 0);
      checkOutput("async_rst_command", 32'(COMMAND_PIN), 32'(NOOP));
      checkOutput("async_rst_stage", 32'(STAGE), 0);
      @(posedge CLK_n);
      #1 RST = 1'b0;
      edge_no = 0;
      runInit(T_RUN);

      repeat (1500) applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
